tt_um_seq_divider_hhrb98: RTL and testbench

- Sequential unsigned restoring divider; functional inverse of the team's 4x4 array multiplier tile.
- Divides an 8-bit dividend by a 4-bit divisor and returns an 8-bit quotient, a 4-bit remainder and a divide-by-zero flag.
- Computes one quotient bit per clock, MSB first, under a start/busy/done handshake.
- Sits as a standard TinyTapeout user tile behind the shared pin wrapper.

---
 rtl/tt_um_seq_divider_hhrb98.sv | 147 ++++++++++++++
 tb/tb_tt_um_seq_divider_hhrb98.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_seq_divider_hhrb98.sv
// Sequential unsigned restoring divider tile: 8-bit dividend / 4-bit divisor.
// Latency: done rises 8 edges after the start edge (1 edge when dividing by zero).
// Backpressure: none; start is ignored while busy, ena=0 freezes every register.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   ena           tile enable; all registers hold while low
//   ui_in         dividend
//   uio_in        [3:0] divisor, [4] start, [7] result select, [6:5] unused
//   uio_out       [5] busy, [6] done, other bits 0
//   uio_oe        constant 8'b0110_0000 (busy/done pins driven)
//   uo_out        sel=0: quotient; sel=1: {dz, 3'b000, remainder}
module tt_um_seq_divider_hhrb98 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;    // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;    // latched divisor
  logic [DIVISOR_W:0]    prem_q, prem_d;  // partial remainder
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W-1:0]  divisor_in;
  logic                  start;
  logic                  sel;
  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic                  unused_pins;

  assign divisor_in  = uio_in[DIVISOR_W-1:0];
  assign start       = uio_in[4];
  assign sel         = uio_in[7];
  assign unused_pins = &{1'b0, uio_in[6:5]};

  // Bring down the next dividend bit and test whether the divisor fits.
  assign trial = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
  assign fits  = (trial >= {1'b0, dsr_q});

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_d   = ui_in[DIVIDEND_W-1:0];
            dsr_d   = divisor_in;
            prem_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            // A zero divisor still passes through one CALC edge (which commits
            // the saturated result), so busy stays low for that case.
            busy_d  = (divisor_in != '0);
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (dsr_q == '0) begin
            quo_d   = '1;
            rem_d   = '1;
            dz_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            prem_d = fits ? (trial - {1'b0, dsr_q}) : trial;
            dvd_d  = {dvd_q[DIVIDEND_W-2:0], fits};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              quo_d   = {dvd_q[DIVIDEND_W-2:0], fits};
              rem_d   = prem_d[DIVISOR_W-1:0];
              dz_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uio_out = {1'b0, done_q, busy_q, 5'b0_0000};
  assign uio_oe  = 8'b0110_0000;
  assign uo_out  = sel ? {dz_q, {(7 - DIVISOR_W){1'b0}}, rem_q} : quo_q;

endmodule

// File: tb/tb_tt_um_seq_divider_hhrb98.sv
// Scoreboard bench for the sequential divider tile.
// Stimulus pushes expected result and done cycle; a monitor pops on each done rise.
// Monitor owns the result-select pin; stimulus owns operands, start, ena and reset.
module tb_tt_um_seq_divider_hhrb98;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [3:0] dsr = 4'd0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uio_out, uio_oe, uo_out;
  logic       busy, done;

  assign uio_in = {sel, 2'b00, start, dsr};
  assign busy   = uio_out[5];
  assign done   = uio_out[6];

  tt_um_seq_divider_hhrb98 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: invariant tracking every cycle, full result check on each done rise.
  logic prev_done = 1'b0;
  bit   bd_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && done) bd_seen = 1;
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        sel = 1'b0;
        #1 chk("quotient", uo_out, e.q);
        sel = 1'b1;
        #1 chk("dz_remainder", uo_out, {e.dz, 3'b000, e.r});
        sel = 1'b0;
        chk("uio_oe", uio_oe, 8'h60);
        chk("busy_done_exclusive", bd_seen, 0);
      end
    end
    prev_done = done;
  end

  task automatic start_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                          input logic [3:0] er, input logic edz, input int lat);
    exp_t e;
    ui_in = a;
    dsr   = b;
    start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, (b != 4'd0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      fails++;
      abort = 1;
      $display("FAIL wait_done: done not seen within 60 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    exp_t e;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h60);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    start_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);  wait_done();
    start_op(8'd255, 4'd1, 8'hFF, 4'd0, 1'b0, 8);  wait_done();
    start_op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8); wait_done();
    start_op(8'd7, 4'd9, 8'd0, 4'd7, 1'b0, 8);     wait_done();
    start_op(8'd5, 4'd0, 8'hFF, 4'hF, 1'b1, 1);    wait_done();

    // Start with other operands in the middle of CALC is ignored
    start_op(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8);
    repeat (2) @(negedge clk);
    ui_in = 8'd50; dsr = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start held high: a second operation begins from DONE immediately
    ui_in = 8'd20; dsr = 4'd3; start = 1'b1;
    e.q = 8'd6; e.r = 4'd2; e.dz = 1'b0; e.cyc = cyc + 1 + 8;
    sb.push_back(e);
    e.cyc = cyc + 1 + 9 + 8;
    sb.push_back(e);
    repeat (10) @(negedge clk);
    chk("held_start_done_drops", done, 1'b0);
    chk("held_start_busy", busy, 1'b1);
    start = 1'b0;
    wait_done();

    // ena low for 5 cycles mid-CALC delays done by exactly 5
    start_op(8'd60, 4'd7, 8'd8, 4'd4, 1'b0, 13);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    wait_done();

    // Reset mid-CALC discards the operation
    ui_in = 8'd100; dsr = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_uo_out", uo_out, 8'h00);
    chk("midreset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_reset_no_done", uio_out, 8'h00);
    start_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 8); wait_done();

    // Exhaustive operand sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (!abort) begin
          if (b == 0) start_op(8'(a), 4'(b), 8'hFF, 4'hF, 1'b1, 1);
          else        start_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 8);
          wait_done();
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
